// File: rtl/ifu_prefetch_queue_if.sv
// Instruction memory channel: req/gnt request handshake plus in-order rvalid responses.
interface ifu_prefetch_queue_if #(
  parameter int PC_WD   = 64,
  parameter int INST_WD = 32
);
  logic               inst_req;
  logic [PC_WD-1:0]   inst_addr;
  logic               inst_gnt;
  logic               inst_rvalid;
  logic [INST_WD-1:0] inst_rdata;

  modport master (
    output inst_req, inst_addr,
    input  inst_gnt, inst_rvalid, inst_rdata
  );

  modport slave (
    input  inst_req, inst_addr,
    output inst_gnt, inst_rvalid, inst_rdata
  );
endinterface

// File: rtl/ifu_prefetch_queue.sv
// Instruction fetch front end: in-order prefetch queue between instruction memory and decode,
// with branch redirect flushing the queue and discarding in-flight responses.
module ifu_prefetch_queue #(
  parameter int               PC_WD    = 64,
  parameter int               INST_WD  = 32,
  parameter logic [PC_WD-1:0] RESET_PC = PC_WD'(64'h8000_0000),
  parameter int               DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     br_taken,
  input  logic [PC_WD-1:0]         br_target,
  input  logic                     ds_allowin,
  output logic                     fs_to_ds_valid,
  output logic [INST_WD+PC_WD-1:0] fs_to_ds_bus,
  ifu_prefetch_queue_if.master     imem
);

  localparam int PTR_WD = $clog2(DEPTH);
  localparam int CNT_WD = PTR_WD + 1;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ALLOC  = 2'd1,
    ST_FILLED = 2'd2
  } entry_state_t;

  logic                reset_q_reg;
  logic [PC_WD-1:0]    fetch_pc_reg, fetch_pc_next;
  logic [PTR_WD-1:0]   head_reg, head_next;
  logic [PTR_WD-1:0]   tail_reg, tail_next;
  logic [PTR_WD-1:0]   fill_reg, fill_next;
  logic [CNT_WD-1:0]   occ_reg, occ_next;
  logic [CNT_WD-1:0]   drop_cnt_reg, drop_cnt_next;
  logic [CNT_WD-1:0]   alloc_cnt;
  logic [DEPTH-1:0]    entry_alloc;
  logic [DEPTH-1:0]    entry_filled;
  logic [PC_WD-1:0]    pc_mem   [DEPTH];
  logic [INST_WD-1:0]  inst_mem [DEPTH];
  logic                credit_ok;
  logic                do_alloc, do_fill, do_drop, do_pop;
  logic                unused_br_lsb;

  assign unused_br_lsb = ^br_target[1:0];

  // Credit uses the pre-pop occupancy, so a full queue never refills in its pop cycle.
  assign credit_ok      = (occ_reg + drop_cnt_reg) < CNT_WD'(DEPTH);
  assign imem.inst_req  = !reset_q_reg && credit_ok && !br_taken;
  assign imem.inst_addr = fetch_pc_reg;

  assign do_alloc = imem.inst_req && imem.inst_gnt;
  assign do_drop  = imem.inst_rvalid && (drop_cnt_reg != '0);
  assign do_fill  = imem.inst_rvalid && (drop_cnt_reg == '0) && entry_alloc[fill_reg];

  assign fs_to_ds_valid = entry_filled[head_reg] && !br_taken;
  assign fs_to_ds_bus   = {inst_mem[head_reg], pc_mem[head_reg]};
  assign do_pop         = fs_to_ds_valid && ds_allowin;

  assign alloc_cnt = CNT_WD'($countones(entry_alloc));

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    head_next     = head_reg;
    tail_next     = tail_reg;
    fill_next     = fill_reg;
    occ_next      = occ_reg;
    drop_cnt_next = drop_cnt_reg;
    if (br_taken) begin
      // Every entry still waiting for data becomes a response to discard.
      fetch_pc_next = {br_target[PC_WD-1:2], 2'b00};
      head_next     = '0;
      tail_next     = '0;
      fill_next     = '0;
      occ_next      = '0;
      drop_cnt_next = drop_cnt_reg + alloc_cnt - CNT_WD'(imem.inst_rvalid);
    end else begin
      if (do_alloc) begin
        fetch_pc_next = fetch_pc_reg + PC_WD'(4);
        tail_next     = tail_reg + PTR_WD'(1);
      end
      if (do_fill) fill_next = fill_reg + PTR_WD'(1);
      if (do_pop)  head_next = head_reg + PTR_WD'(1);
      if (do_drop) drop_cnt_next = drop_cnt_reg - CNT_WD'(1);
      occ_next = occ_reg + CNT_WD'(do_alloc) - CNT_WD'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    reset_q_reg <= reset;
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      head_reg     <= '0;
      tail_reg     <= '0;
      fill_reg     <= '0;
      occ_reg      <= '0;
      drop_cnt_reg <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      fill_reg     <= fill_next;
      occ_reg      <= occ_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        inst_mem[i] <= '0;
      end
    end else begin
      if (do_alloc) pc_mem[tail_reg]   <= fetch_pc_reg;
      if (do_fill)  inst_mem[fill_reg] <= imem.inst_rdata;
    end
  end

  // Per-entry lifecycle EMPTY -> ALLOC -> FILLED -> EMPTY; the three events never hit one entry together.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      entry_state_t state_reg, state_next;

      always_comb begin
        state_next = state_reg;
        if (br_taken) begin
          state_next = ST_EMPTY;
        end else begin
          if (do_alloc && (tail_reg == PTR_WD'(gi))) state_next = ST_ALLOC;
          if (do_fill  && (fill_reg == PTR_WD'(gi))) state_next = ST_FILLED;
          if (do_pop   && (head_reg == PTR_WD'(gi))) state_next = ST_EMPTY;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_EMPTY;
        else       state_reg <= state_next;
      end

      assign entry_alloc[gi]  = (state_reg == ST_ALLOC);
      assign entry_filled[gi] = (state_reg == ST_FILLED);
    end
  endgenerate

  a_rvalid_expected: assert property (@(posedge clk) disable iff (reset)
    imem.inst_rvalid |-> ((drop_cnt_reg != '0) || entry_alloc[fill_reg]));

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Scoreboard bench for ifu_prefetch_queue: a latency-configurable memory model plus an
// independent fetch-PC model predict every presented {inst, pc}.
module tb_ifu_prefetch_queue;
  localparam int          PC_WD    = 64;
  localparam int          INST_WD  = 32;
  localparam int          DEPTH    = 4;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_taken;
  logic [63:0] br_target;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [95:0] fs_to_ds_bus;

  always #5 clk = ~clk;

  ifu_prefetch_queue_if #(.PC_WD(PC_WD), .INST_WD(INST_WD)) imem_if();

  ifu_prefetch_queue #(
    .PC_WD(PC_WD), .INST_WD(INST_WD), .RESET_PC(RESET_PC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .br_taken(br_taken),
    .br_target(br_target),
    .ds_allowin(ds_allowin),
    .fs_to_ds_valid(fs_to_ds_valid),
    .fs_to_ds_bus(fs_to_ds_bus),
    .imem(imem_if)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;

  req_t        pend[$];
  logic [63:0] exp_q[$];

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc, mem_lat, n_pop, n_gnt;
  bit          gnt_en, br_now, want_first;
  logic [63:0] br_tgt_now, exp_pc, first_pc;
  bit          prev_req, prev_acc;
  logic [63:0] prev_addr;
  bit          obs_valid, obs_req, obs_granted;
  logic [63:0] obs_pc, obs_addr;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [63:0] a);
    return {a[31:2], 2'b11} ^ a[63:32] ^ 32'hC3A5_1E0F;
  endfunction

  // One bus cycle: drive inputs, observe #1 later, update models, advance to next negedge.
  task automatic step();
    req_t        r;
    logic [63:0] e;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      r = pend.pop_front();
      imem_if.inst_rvalid = 1'b1;
      imem_if.inst_rdata  = mem_data(r.addr);
    end else begin
      imem_if.inst_rvalid = 1'b0;
      imem_if.inst_rdata  = '0;
    end
    imem_if.inst_gnt = gnt_en;
    br_taken  = br_now;
    br_target = br_tgt_now;
    #1;
    obs_valid   = fs_to_ds_valid;
    obs_req     = imem_if.inst_req;
    obs_addr    = imem_if.inst_addr;
    obs_pc      = fs_to_ds_bus[63:0];
    obs_granted = obs_req && gnt_en;
    if (prev_req && !prev_acc && !br_now) begin
      check_val("req_hold", 128'(obs_req), 128'(1'b1));
      check_val("addr_hold", 128'(obs_addr), 128'(prev_addr));
    end
    if (br_now) begin
      check_val("br_valid", 128'(obs_valid), 128'(1'b0));
      check_val("br_req", 128'(obs_req), 128'(1'b0));
    end
    if (obs_valid && ds_allowin) begin
      n_pop++;
      if (want_first) begin
        first_pc   = obs_pc;
        want_first = 1'b0;
      end
      if (exp_q.size() == 0) begin
        check_val("spurious_valid", 128'(obs_valid), 128'(1'b0));
      end else begin
        e = exp_q.pop_front();
        check_val("pop_pc", 128'(obs_pc), 128'(e));
        check_val("pop_inst", 128'(fs_to_ds_bus[95:64]), 128'(mem_data(e)));
      end
    end
    if (obs_granted) begin
      n_gnt++;
      check_val("gnt_addr", 128'(obs_addr), 128'(exp_pc));
      pend.push_back('{addr: obs_addr, due: cyc + mem_lat});
      exp_q.push_back(exp_pc);
      exp_pc = exp_pc + 64'd4;
    end
    if (br_now) begin
      exp_q.delete();
      exp_pc = {br_tgt_now[63:2], 2'b00};
    end
    $display("[TB] cyc=%0d req=%0b addr=0x%0h gnt=%0b rv=%0b br=%0b valid=%0b pc=0x%0h",
             cyc, obs_req, obs_addr, obs_granted, imem_if.inst_rvalid, br_now, obs_valid, obs_pc);
    prev_req  = obs_req;
    prev_acc  = obs_granted;
    prev_addr = obs_addr;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    br_now = 1'b0;
  endtask

  // Reset for two edges; outputs are checked right after the first one. Memory is reset too.
  task automatic do_reset();
    reset = 1'b1;
    br_taken = 1'b0;
    br_now = 1'b0;
    imem_if.inst_gnt = 1'b0;
    imem_if.inst_rvalid = 1'b0;
    imem_if.inst_rdata = '0;
    @(posedge clk);
    #1;
    check_val("rst_req", 128'(imem_if.inst_req), 128'(1'b0));
    check_val("rst_addr", 128'(imem_if.inst_addr), 128'(RESET_PC));
    check_val("rst_valid", 128'(fs_to_ds_valid), 128'(1'b0));
    check_val("rst_bus", 128'(fs_to_ds_bus), 128'(0));
    check_val("rst_drop", 128'(dut.drop_cnt_reg), 128'(0));
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    pend.delete();
    exp_q.delete();
    exp_pc = RESET_PC;
    prev_req = 1'b0;
    prev_acc = 1'b0;
    want_first = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_first(input string tag, input logic [63:0] pc_exp);
    for (int k = 0; k < 40 && want_first; k++) step();
    check_val({tag, "_seen"}, 128'(want_first), 128'(1'b0));
    check_val({tag, "_pc"}, 128'(first_pc), 128'(pc_exp));
  endtask

  initial begin
    logic [63:0] resume_addr;
    bit          resume_seen;
    reset = 1'b1;
    br_taken = 1'b0;
    br_target = '0;
    br_tgt_now = '0;
    ds_allowin = 1'b1;
    gnt_en = 1'b1;
    mem_lat = 1;
    imem_if.inst_gnt = 1'b0;
    imem_if.inst_rvalid = 1'b0;
    imem_if.inst_rdata = '0;
    @(negedge clk);

    // Streaming with 1-cycle memory: first valid at cycle 3, then no bubbles.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) check_val("t1_req_c0", 128'(obs_req), 128'(1'b0));
      if (i == 1) check_val("t1_req_c1", 128'(obs_req), 128'(1'b1));
      if (i < 3) begin
        check_val("t1_valid_early", 128'(obs_valid), 128'(1'b0));
      end else begin
        check_val("t1_valid", 128'(obs_valid), 128'(1'b1));
        check_val("t1_pc", 128'(obs_pc), 128'(RESET_PC + 64'(4 * (i - 3))));
      end
    end

    // Decode stalled: exactly DEPTH grants, then in-order drain and resume.
    do_reset();
    ds_allowin = 1'b0;
    n_gnt = 0;
    for (int i = 0; i < 10; i++) step();
    check_val("t2_grants", 128'(n_gnt), 128'(DEPTH));
    check_val("t2_req_low", 128'(obs_req), 128'(1'b0));
    ds_allowin = 1'b1;
    n_pop = 0;
    resume_seen = 1'b0;
    resume_addr = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (obs_granted && !resume_seen) begin
        resume_seen = 1'b1;
        resume_addr = obs_addr;
      end
    end
    check_val("t2_resume_addr", 128'(resume_addr), 128'(64'h8000_0010));
    check_val("t2_drained", 128'(n_pop >= 4), 128'(1'b1));

    // Slow memory, redirect with 3 outstanding requests.
    do_reset();
    mem_lat = 5;
    for (int k = 0; k < 10 && pend.size() < 3; k++) step();
    br_now = 1'b1;
    br_tgt_now = 64'h8000_1002;
    want_first = 1'b1;
    step();
    check_val("t3_drop", 128'(dut.drop_cnt_reg), 128'(3));
    wait_first("t3_first", 64'h8000_1000);
    check_val("t3_drop_end", 128'(dut.drop_cnt_reg), 128'(0));

    // Redirect coinciding with rvalid and gnt, two entries awaiting data.
    do_reset();
    mem_lat = 2;
    for (int i = 0; i < 3; i++) step();
    br_now = 1'b1;
    br_tgt_now = 64'h0000_0000_0000_4000;
    want_first = 1'b1;
    step();
    check_val("t4_drop", 128'(dut.drop_cnt_reg), 128'(1));
    step();
    check_val("t4_restart_req", 128'(obs_req), 128'(1'b1));
    check_val("t4_restart_addr", 128'(obs_addr), 128'(64'h4000));
    wait_first("t4_first", 64'h4000);

    // Grant withheld, then fetch PC wraps past the top of the address space.
    do_reset();
    mem_lat = 1;
    gnt_en = 1'b0;
    step();
    br_now = 1'b1;
    br_tgt_now = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("t5_req_stall", 128'(obs_req), 128'(1'b1));
      check_val("t5_addr_stall", 128'(obs_addr), 128'(64'hFFFF_FFFF_FFFF_FFFC));
    end
    gnt_en = 1'b1;
    want_first = 1'b1;
    step();
    check_val("t5_gnt_top", 128'(obs_granted), 128'(1'b1));
    step();
    check_val("t5_wrap_addr", 128'(obs_addr), 128'(64'h0));
    wait_first("t5_first", 64'hFFFF_FFFF_FFFF_FFFC);
    for (int i = 0; i < 6; i++) step();

    // Reset in the middle of a stalled, redirected stream.
    do_reset();
    mem_lat = 3;
    ds_allowin = 1'b0;
    for (int i = 0; i < 5; i++) step();
    br_now = 1'b1;
    br_tgt_now = 64'h2000;
    step();
    check_val("t6_drop", 128'(dut.drop_cnt_reg), 128'(2));
    do_reset();
    ds_allowin = 1'b1;
    mem_lat = 1;
    want_first = 1'b1;
    wait_first("t6_first", RESET_PC);

    // Random grants, stalls and redirects.
    do_reset();
    mem_lat = 2;
    n_pop = 0;
    for (int i = 0; i < 300; i++) begin
      gnt_en = ($urandom % 4) != 0;
      ds_allowin = ($urandom % 4) != 0;
      br_now = ($urandom % 23) == 0;
      br_tgt_now = {$urandom, $urandom};
      step();
    end
    gnt_en = 1'b1;
    ds_allowin = 1'b1;
    for (int i = 0; i < 20; i++) step();
    check_val("rand_progress", 128'(n_pop > 20), 128'(1'b1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end
endmodule
